ecc_decode32_pipe: RTL and testbench
====================================

Name: ecc_decode32_pipe

Overview:
- Read-side SEC-DED checker/corrector for the ECC-protected FIFO. Sits directly downstream of the FIFO storage, which holds each 32-bit word plus the 7-bit check field produced by the write-side encoder.
- Accepts {data, ecc} with valid/ready, and returns corrected data plus error flags two cycles later.
- Keeps saturating counts of corrected (SEC) and uncorrectable (DED) events for software.

Parameters:
- DATA_W, 32, data width; fixed, other values unsupported.
- ECC_W, 7, check width, laid out as {p[5:0], p0}.
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept the input word
- in_data  in  32  stored data
- in_ecc  in  7  stored check bits {p[5:0], p0}
- out_valid  out  1  corrected word valid
- out_ready  in  1  consumer accepts the word
- out_data  out  32  corrected data
- out_sec  out  1  single error was corrected (data bit, p bit or p0)
- out_ded  out  1  uncorrectable error; out_data is the raw data
- out_syndrome  out  7  {s[5:0], ov}, for debug
- cnt_clr  in  1  synchronous clear of both counters
- cnt_sec  out  CNT_W  saturating count of SEC words
- cnt_ded  out  CNT_W  saturating count of DED words

Behaviour:
- Code definition (must match the encoder exactly):
  - Hamming positions 1..38. Data bits d[0..31] occupy the non-power-of-2 positions in ascending order, so d[0] is at position 3 and d[31] at position 38.
  - p[k] is the XOR of the data at every position whose index has bit k set.
  - p0 is the XOR of all 32 data bits and p[5:0].
- Stage 1 (on acceptance):
  - Register data and ecc.
  - s[k] = in_ecc[k+1] XOR recomputed p[k].
  - ov = XOR of in_data, in_ecc[6:1] and in_ecc[0].
  - Register s and ov.
- Stage 2 classification, using S = s as an integer:
  - ov=0, S=0: clean. sec=0, ded=0.
  - ov=1, S=0: p0 error. sec=1; data unchanged.
  - ov=1, S a power of 2 (1,2,4,8,16,32): p-bit error. sec=1; data unchanged.
  - ov=1, S a data position (3..38, not a power of 2): flip the data bit at that position. sec=1.
  - ov=1, S in 39..63: ded=1; raw data passed through.
  - ov=0, S≠0: ded=1; raw data passed through.
- sec and ded are never both 1.
- Latency: exactly 2 clk cycles from input handshake to out_valid when not stalled. Throughput is 1 word/cycle.
- Handshake:
  - Each stage has a valid bit. A stage loads when it is empty or its contents move on that cycle.
  - in_ready = !v1 | !v2 | out_ready (combinational, no dependence on in_valid).
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - No word is lost or duplicated under any valid/ready pattern.
- Counters:
  - Increment on an output handshake (out_valid & out_ready) with sec=1 (cnt_sec) or ded=1 (cnt_ded).
  - Saturate at all-ones.
  - cnt_clr has priority over a same-cycle increment; that increment is dropped.
- Reset (async assert, sync deassert is handled externally):
  - v1=v2=0, so out_valid=0.
  - out_data, out_sec, out_ded, out_syndrome and both counters = 0.
  - in_ready=1 immediately after reset.
  - A reset mid-stream discards all in-flight words.

Decomposition:
- ecc_pkg holds:
  - DATA_W, ECC_W, NPOS=38.
  - A function mapping data index to Hamming position.
  - A parity-vector function shared with the encoder so both sides use identical maps.
- Sub-module ecc_syndrome32 (combinational): inputs data and ecc; outputs s[5:0] and ov. Instantiated in stage 1.

Test Plan:
- data=0x00000000, ecc=0x00 → out_data=0, sec=0, ded=0, syndrome=0; out_valid 2 cycles after the handshake; counters unchanged.
- data=0x00000001 (d[0] flipped), ecc=0x00 → syndrome s=3, ov=1; out_data=0x00000000, sec=1; cnt_sec=1.
- data=0x00000000, ecc=0x01 (p0 flipped) → sec=1, out_data=0; also data=0, ecc=0x02 (p[0] flipped) → s=1, ov=1, sec=1.
- data=0x00000003 (d[0], d[1] flipped, positions 3 and 5), ecc=0x00 → s=6, ov=0, ded=1, out_data=0x00000003; cnt_ded=1.
- Backpressure: stream 8 clean words with out_ready toggled randomly → all 8 appear in order, none duplicated, outputs stable while stalled.
- Counters: preset cnt_sec to 0xFFFF, then send an SEC word → stays 0xFFFF. Assert cnt_clr in the same cycle as an SEC output handshake → cnt_sec=0. Assert rst_n low mid-stream → out_valid=0 at once and counters=0.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the 32-bit SEC-DED code used by the FIFO encoder and
// decoder. Both sides call parity_vec() so the data-to-position map cannot
// drift between them.
//   DATA_W / ECC_W / NPOS : code geometry (check field is {p[5:0], p0})
//   data_pos()            : data bit index -> Hamming position (1..38)
//   parity_vec()          : p[5:0] for a data word
//   dec_out_t             : one decoded word as it leaves the pipeline
package ecc_pkg;

  localparam int DATA_W = 32;
  localparam int ECC_W  = 7;
  localparam int SYN_W  = 6;
  localparam int NPOS   = 38;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sec;
    logic              ded;
    logic [ECC_W-1:0]  syn;   // {s[5:0], ov}
  } dec_out_t;

  // Data bits fill the non-power-of-2 positions in ascending order.
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p <= NPOS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // p[k] covers every data position whose index has bit k set.
  function automatic logic [SYN_W-1:0] parity_vec(input logic [DATA_W-1:0] d);
    logic [SYN_W-1:0] p;
    int               pos;
    p = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pos = data_pos(i);
      for (int k = 0; k < SYN_W; k++) begin
        if (pos[k]) p[k] = p[k] ^ d[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ecc_syndrome32.sv
// Combinational syndrome generator for one stored word.
//   i_data  : stored 32-bit data
//   i_ecc   : stored check field {p[5:0], p0}
//   o_syn   : s[5:0], stored p[k] XOR recomputed p[k]
//   o_ov    : overall parity across data and all check bits
module ecc_syndrome32
  import ecc_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [ECC_W-1:0]  i_ecc,
  output logic [SYN_W-1:0]  o_syn,
  output logic              o_ov
);

  assign o_syn = i_ecc[ECC_W-1:1] ^ parity_vec(i_data);
  assign o_ov  = ^{i_data, i_ecc};

endmodule

// File: rtl/ecc_decode32_pipe.sv
// Two-stage SEC-DED checker/corrector on the FIFO read side.
// Stage 1 captures the data with its syndrome; stage 2 holds the corrected
// word and flags until the consumer takes them. Saturating SEC/DED counters
// advance on each output handshake.
//   in_valid/in_ready/in_data/in_ecc   : stored word from the FIFO
//   out_valid/out_ready/out_data       : corrected word to the consumer
//   out_sec/out_ded/out_syndrome       : error classification, {s, ov}
//   cnt_clr/cnt_sec/cnt_ded            : software error counters
module ecc_decode32_pipe
  import ecc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [ECC_W-1:0]     in_ecc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_sec,
  output logic                 out_ded,
  output logic [ECC_W-1:0]     out_syndrome,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     cnt_sec,
  output logic [CNT_W-1:0]     cnt_ded
);

  logic              w_ld1;
  logic              w_ld2;
  logic              w_out_fire;
  logic [SYN_W-1:0]  w_syn;
  logic              w_ov;
  dec_out_t          w_dec;

  logic              r_v1;
  logic [DATA_W-1:0] r_data1;
  logic [SYN_W-1:0]  r_syn1;
  logic              r_ov1;
  logic              r_v2;
  dec_out_t          r_st2;
  logic [CNT_W-1:0]  r_cnt_sec;
  logic [CNT_W-1:0]  r_cnt_ded;

  // A stage loads when empty or when its word moves on this cycle.
  assign w_ld2      = !r_v2 || out_ready;
  assign w_ld1      = !r_v1 || w_ld2;
  assign in_ready   = w_ld1;
  assign w_out_fire = r_v2 && out_ready;

  ecc_syndrome32 u_syn (
    .i_data (in_data),
    .i_ecc  (in_ecc),
    .o_syn  (w_syn),
    .o_ov   (w_ov)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
    end else if (w_ld1) begin
      r_v1 <= in_valid;
    end
  end

  // NOTE: stage-1 payload is qualified by r_v1, so it needs no reset; leaving
  // it out keeps the reset tree to the control bits and visible outputs.
  always_ff @(posedge clk) begin
    if (w_ld1 && in_valid) begin
      r_data1 <= in_data;
      r_syn1  <= w_syn;
      r_ov1   <= w_ov;
    end
  end

  // Stage-2 classification of the word held in stage 1.
  // NOTE: every field gets a default first so no path leaves a latch behind.
  always_comb begin
    logic [DATA_W-1:0] flip;
    flip        = '0;
    w_dec       = '0;
    w_dec.syn   = {r_syn1, r_ov1};
    if (!r_ov1) begin
      w_dec.ded = (r_syn1 != '0);
    end else if (int'(r_syn1) <= NPOS) begin
      // S=0 (p0) and power-of-2 S (p bits) match no data position: no flip.
      w_dec.sec = 1'b1;
      for (int i = 0; i < DATA_W; i++) begin
        if (int'(r_syn1) == data_pos(i)) flip[i] = 1'b1;
      end
    end else begin
      w_dec.ded = 1'b1;
    end
    w_dec.data = r_data1 ^ flip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2  <= 1'b0;
      r_st2 <= '0;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) r_st2 <= w_dec;
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_sec <= '0;
      r_cnt_ded <= '0;
    end else if (cnt_clr) begin
      r_cnt_sec <= '0;
      r_cnt_ded <= '0;
    end else if (w_out_fire) begin
      if (r_st2.sec && (r_cnt_sec != '1)) r_cnt_sec <= r_cnt_sec + 1'b1;
      if (r_st2.ded && (r_cnt_ded != '1)) r_cnt_ded <= r_cnt_ded + 1'b1;
    end
  end

  assign out_valid    = r_v2;
  assign out_data     = r_st2.data;
  assign out_sec      = r_st2.sec;
  assign out_ded      = r_st2.ded;
  assign out_syndrome = r_st2.syn;
  assign cnt_sec      = r_cnt_sec;
  assign cnt_ded      = r_cnt_ded;

endmodule

// File: tb/tb_ecc_decode32_pipe.sv
// Self-checking bench for ecc_decode32_pipe. The reference treats each word
// as a 39-bit Hamming codeword (bit 0 = p0, bit 2^k = p[k], others data),
// builds clean codewords, injects 0/1/2 bit errors and derives the expected
// result from the injection itself; a scoreboard queue tracks ordering.
module tb_ecc_decode32_pipe;

  typedef struct {
    logic [31:0] data;
    logic        sec;
    logic        ded;
    logic [6:0]  syn;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [6:0]  in_ecc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sec;
  logic        out_ded;
  logic [6:0]  out_syndrome;
  logic        cnt_clr;
  logic [15:0] cnt_sec;
  logic [15:0] cnt_ded;

  int          checks;
  int          errors;
  int          dpos[32];
  exp_t        sb[$];
  exp_t        nxt;
  exp_t        held;
  logic        stall_prev;
  logic        last_in_fire;
  int          n_out;
  logic [15:0] m_sec;
  logic [15:0] m_ded;

  ecc_decode32_pipe #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_ecc       (in_ecc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sec      (out_sec),
    .out_ded      (out_ded),
    .out_syndrome (out_syndrome),
    .cnt_clr      (cnt_clr),
    .cnt_sec      (cnt_sec),
    .cnt_ded      (cnt_ded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [38:0] to_cw(input logic [31:0] d, input logic [6:0] e);
    logic [38:0] cw;
    cw    = '0;
    cw[0] = e[0];
    for (int k = 0; k < 6; k++) cw[1 << k] = e[k+1];
    for (int i = 0; i < 32; i++) cw[dpos[i]] = d[i];
    return cw;
  endfunction

  function automatic logic [38:0] from_cw(input logic [38:0] cw);  // {data, ecc}
    logic [31:0] d;
    logic [6:0]  e;
    e[0] = cw[0];
    for (int k = 0; k < 6; k++) e[k+1] = cw[1 << k];
    for (int i = 0; i < 32; i++) d[i] = cw[dpos[i]];
    return {d, e};
  endfunction

  // Pick p so the XOR of all set-bit positions is zero, then even overall parity.
  function automatic logic [6:0] encode(input logic [31:0] d);
    logic [5:0] x;
    x = '0;
    for (int i = 0; i < 32; i++) if (d[i]) x = x ^ 6'(dpos[i]);
    return {x, (^d) ^ (^x)};
  endfunction

  function automatic logic [6:0] ref_syn(input logic [38:0] cw);
    logic [5:0] x;
    x = '0;
    for (int j = 1; j <= 38; j++) if (cw[j]) x = x ^ 6'(j);
    return {x, ^cw};
  endfunction

  // Random word with 0, 1 or 2 injected codeword errors.
  task automatic make_random(output logic [31:0] rd, output logic [6:0] re, output exp_t ex);
    logic [31:0] d;
    logic [38:0] cw;
    int          n;
    int          a;
    int          b;
    d  = 32'($urandom);
    cw = to_cw(d, encode(d));
    n  = int'($urandom_range(0, 2));
    a  = int'($urandom_range(0, 38));
    b  = (a + 1 + int'($urandom_range(0, 37))) % 39;
    if (n >= 1) cw[a] = ~cw[a];
    if (n == 2) cw[b] = ~cw[b];
    {rd, re} = from_cw(cw);
    ex.data = (n == 2) ? rd : d;
    ex.sec  = (n == 1);
    ex.ded  = (n == 2);
    ex.syn  = ref_syn(cw);
  endtask

  // One clock: sample at negedge+1, score, then advance to the next negedge.
  task automatic step();
    logic in_fire;
    logic out_fire;
    exp_t e;
    #1;
    check("cnt_sec", 32'(cnt_sec), 32'(m_sec));
    check("cnt_ded", 32'(cnt_ded), 32'(m_ded));
    if (stall_prev) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, held.data);
      check("hold_flags", {22'd0, out_sec, out_ded, 1'b0, out_syndrome},
            {22'd0, held.sec, held.ded, 1'b0, held.syn});
    end
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (out_fire) begin
      if (sb.size() == 0) begin
        check("spurious_out", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        n_out++;
        check("out_data", out_data, e.data);
        check("out_sec", 32'(out_sec), 32'(e.sec));
        check("out_ded", 32'(out_ded), 32'(e.ded));
        check("out_syndrome", 32'(out_syndrome), 32'(e.syn));
        if (!cnt_clr) begin
          if (e.sec && m_sec != 16'hFFFF) m_sec++;
          if (e.ded && m_ded != 16'hFFFF) m_ded++;
        end
      end
    end
    if (cnt_clr) begin
      m_sec = '0;
      m_ded = '0;
    end
    stall_prev   = out_valid && !out_ready;
    held.data    = out_data;
    held.sec     = out_sec;
    held.ded     = out_ded;
    held.syn     = out_syndrome;
    if (in_fire) sb.push_back(nxt);
    last_in_fire = in_fire;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single word through an empty pipe, checking the two-cycle latency.
  task automatic send_isolated(input logic [31:0] d, input logic [6:0] e,
                               input logic [31:0] xd, input logic xs, input logic xded,
                               input logic [6:0] xsyn, input logic clr);
    in_valid  = 1'b1;
    in_data   = d;
    in_ecc    = e;
    out_ready = 1'b1;
    nxt.data  = xd;
    nxt.sec   = xs;
    nxt.ded   = xded;
    nxt.syn   = xsyn;
    step();
    in_valid = 1'b0;
    #1 check("latency_c1", 32'(out_valid), 32'd0);
    step();
    #1 check("latency_c2", 32'(out_valid), 32'd1);
    cnt_clr = clr;
    step();
    cnt_clr = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [6:0]  re;
    exp_t        ex;
    int          sent;
    int          base;
    int          guard;
    logic        need;

    checks = 0; errors = 0; n_out = 0;
    m_sec = '0; m_ded = '0;
    stall_prev = 1'b0; last_in_fire = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ecc = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    begin
      int c;
      c = 0;
      for (int p = 1; p <= 38; p++) if ($countones(p) != 1) begin dpos[c] = p; c++; end
    end

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", out_data, 32'd0);
    check("rst_flags", {29'd0, out_sec, out_ded, 1'b0}, 32'd0);
    check("rst_syndrome", 32'(out_syndrome), 32'd0);
    check("rst_counters", {cnt_sec, cnt_ded}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed words
    send_isolated(32'h0000_0000, 7'h00, 32'h0000_0000, 1'b0, 1'b0, 7'h00, 1'b0);
    check("clean_no_count", {cnt_sec, cnt_ded}, 32'd0);
    send_isolated(32'h0000_0001, 7'h00, 32'h0000_0000, 1'b1, 1'b0, 7'h07, 1'b0);
    #1 check("d0_cnt_sec", 32'(cnt_sec), 32'd1);
    send_isolated(32'h0000_0000, 7'h01, 32'h0000_0000, 1'b1, 1'b0, 7'h01, 1'b0);
    send_isolated(32'h0000_0000, 7'h02, 32'h0000_0000, 1'b1, 1'b0, 7'h03, 1'b0);
    send_isolated(32'h0000_0003, 7'h00, 32'h0000_0003, 1'b0, 1'b1, 7'h0C, 1'b0);
    #1 check("ded_cnt", 32'(cnt_ded), 32'd1);
    // d[31] at position 38: syndrome 38, ov=1
    send_isolated(32'h8000_0000, 7'h00, 32'h0000_0000, 1'b1, 1'b0, {6'd38, 1'b1}, 1'b0);

    // Clear in the same cycle as an SEC output handshake
    send_isolated(32'h0000_0000, 7'h01, 32'h0000_0000, 1'b1, 1'b0, 7'h01, 1'b1);
    #1 check("clr_cnt_sec", 32'(cnt_sec), 32'd0);
    check("clr_cnt_ded", 32'(cnt_ded), 32'd0);

    // Backpressure: 8 clean words, random out_ready
    base = n_out; sent = 0; need = 1'b1;
    for (int cyc = 0; cyc < 300 && (sent < 8 || sb.size() > 0); cyc++) begin
      if (need && sent < 8) begin
        in_data  = 32'($urandom);
        in_ecc   = encode(in_data);
        nxt.data = in_data; nxt.sec = 1'b0; nxt.ded = 1'b0; nxt.syn = 7'h00;
        need     = 1'b0;
      end
      in_valid  = (sent < 8);
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (last_in_fire) begin sent++; need = 1'b1; end
    end
    in_valid = 1'b0;
    check("bp_count", 32'(n_out - base), 32'd8);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Random errors with random valid/ready
    base = n_out; sent = 0; need = 1'b1;
    for (int cyc = 0; cyc < 2000 && (sent < 150 || sb.size() > 0); cyc++) begin
      if (need && sent < 150) begin
        make_random(rd, re, ex);
        in_data = rd; in_ecc = re; nxt = ex;
        need = 1'b0;
      end
      if (!in_valid || last_in_fire || sent >= 150)
        in_valid = (sent < 150) && 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      step();
      if (last_in_fire) begin sent++; need = 1'b1; end
    end
    in_valid = 1'b0;
    check("rand_count", 32'(n_out - base), 32'd150);

    // Drive cnt_sec to saturation with p0 errors at full rate
    in_valid = 1'b1; out_ready = 1'b1; guard = 0;
    while (m_sec != 16'hFFFF && guard < 70000) begin
      in_data  = 32'($urandom);
      in_ecc   = encode(in_data) ^ 7'h01;
      nxt.data = in_data; nxt.sec = 1'b1; nxt.ded = 1'b0; nxt.syn = 7'h01;
      step();
      guard++;
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("sat_reached", 32'(cnt_sec), 32'h0000_FFFF);
    send_isolated(32'h0000_0001, 7'h00, 32'h0000_0000, 1'b1, 1'b0, 7'h07, 1'b0);
    #1 check("sat_hold", 32'(cnt_sec), 32'h0000_FFFF);

    // Reset mid-stream with both stages full and stalled
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data  = 32'($urandom);
      in_ecc   = encode(in_data);
      nxt.data = in_data; nxt.sec = 1'b0; nxt.ded = 1'b0; nxt.syn = 7'h00;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_counters", {cnt_sec, cnt_ded}, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    sb.delete();
    m_sec = '0; m_ded = '0; stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_isolated(32'hDEAD_BEEF, encode(32'hDEAD_BEEF), 32'hDEAD_BEEF, 1'b0, 1'b0, 7'h00, 1'b0);
    check("post_rst_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
